arbitro_registro_rr: RTL and testbench
======================================

# arbitro_registro_rr

Round-robin write arbiter that shares one 4-bit enabled D register among up to four requesters. Each write is a req/ack handshake: the arbiter picks one requester, drives the register's enable and data inputs for exactly one cycle, then acknowledges that requester. It sits directly in front of the shared register instance (EN/D inputs) and is the only block allowed to drive them.

## Interface
- N_REQ, 4: number of requesters (2..4)
- WIDTH, 4: data width, equals the shared register width
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  N_REQ  per-requester write request, level, held until ack
- d_in  input  N_REQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  output  N_REQ  one-hot grant of current transaction, 0 when idle
- ack  output  N_REQ  one-cycle completion pulse to the granted requester
- en_out  output  1  enable to shared register (connects to EN)
- d_out  output  WIDTH  data to shared register (connects to D)
- owner  output  2  index of requester that performed the last completed write
- busy  output  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, WRITE, ACK; encoding free, one state per cycle.
- IDLE: if any req bit is high, select winner by round-robin search starting at index ptr, increasing, wrapping at N_REQ; on the clock edge register gnt = one-hot(winner), d_out = d_in slice of winner, go to WRITE. If req == 0, stay in IDLE, outputs unchanged except gnt = 0.
- WRITE: en_out = 1 (Moore output of WRITE); d_out held constant; go to ACK unconditionally.
- ACK: ack[winner] = 1 (Moore output, gated by gnt); on exit: ptr <= (winner+1) mod N_REQ, owner <= winner, gnt <= 0, go to IDLE.
- d_out keeps the last written value after the transaction; it changes only when a new grant is issued.
- Requests arriving during WRITE/ACK are ignored until the next IDLE cycle; no queueing.
- Winner dropping req during WRITE/ACK: write still completes and ack still pulses; data is already latched in d_out.
- Requester still asserting req in the IDLE cycle after its ack counts as a new request, but ptr has already rotated past it, so any other pending requester wins first.
- req bits at index >= N_REQ do not exist; ptr wraps using N_REQ, not 4.
- Async reset (rst_n low, any state, including mid-WRITE): state = IDLE, ptr = 0, gnt = 0, ack = 0, en_out = 0, d_out = 0, owner = 0, busy = 0. A write interrupted by reset is not acknowledged; the register may or may not have captured it.

## Timing
- Edge k (IDLE, req seen): gnt, d_out, busy valid after edge k.
- Cycle k..k+1: en_out = 1; shared register captures d_out at edge k+1.
- Cycle k+1..k+2: ack pulse; register Q already holds new data (ack coincides with valid Q).
- Edge k+2: back to IDLE; earliest next grant at edge k+3.
- Throughput: one write per 3 cycles; latency req-to-ack 2 cycles after the sampling edge.
- en_out and ack are never high in the same cycle; at most one gnt/ack bit high at any time.
- Worst-case wait for a continuously requesting input: (N_REQ-1) transactions = 9 cycles for N_REQ=4.

## Test plan
- Reset: rst_n=0 with req=4'b1111 -> all outputs 0, busy=0; release, first grant goes to requester 0 (ptr=0).
- Single write: req=4'b0100, d_in slice 2 = 4'b1010 -> gnt=0100, en_out one cycle, ack[2] next cycle, register Q=1010 at ack, owner=2.
- Fairness: req=4'b1111 held, each requester deasserting after its ack and reasserting -> grant order 0,1,2,3,0 with data 0001,0010,0100,1000 written in that order, one ack every 3 cycles.
- Hold behaviour: after writing 1111, req=0 and d_in changes to 0000 -> en_out stays 0, d_out and Q remain 1111.
- Drop mid-write: requester 1 grants with 0110, deasserts req during WRITE -> ack[1] still pulses, Q=0110.
- Reset mid-operation: rst_n low during WRITE -> en_out, gnt, ack 0 immediately; no ack issued; ptr=0 after release.

Source files
------------

// File: rtl/arbitro_registro_rr.sv
// Round-robin write arbiter in front of one shared enabled D register.
// Each grant drives EN/D for one cycle, then pulses ack to the winner.
module arbitro_registro_rr #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   d_in,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         ack,
  output logic                     en_out,
  output logic [WIDTH-1:0]         d_out,
  output logic [1:0]               owner,
  output logic                     busy
);

  // state | meaning
  // IDLE  | waiting for a request; winner chosen on the edge leaving IDLE
  // WRITE | en_out high, shared register captures d_out at end of cycle
  // ACK   | ack pulse to winner; pointer rotates and owner updates on exit
  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  state_t             state;
  logic [1:0]         ptr;
  logic [1:0]         win_q;
  logic [1:0]         win_idx;
  logic               found;
  logic [N_REQ-1:0]   win_oh;
  logic [WIDTH-1:0]   win_data;
  logic [1:0]         ptr_next;

  // Indices at or above ptr always beat those below it; within each group
  // the descending loop leaves the lowest index as the final assignment.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    win_oh   = '0;
    win_data = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (req[i] && (i < int'(ptr))) begin
        found     = 1'b1;
        win_idx   = 2'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_data  = d_in[i*WIDTH +: WIDTH];
      end
    end
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        found     = 1'b1;
        win_idx   = 2'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_data  = d_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign ptr_next = (win_q == 2'(N_REQ-1)) ? 2'd0 : win_q + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      win_q  <= '0;
      gnt    <= '0;
      ack    <= '0;
      en_out <= 1'b0;
      d_out  <= '0;
      owner  <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (found) begin
            gnt    <= win_oh;
            d_out  <= win_data;
            win_q  <= win_idx;
            en_out <= 1'b1;
            busy   <= 1'b1;
            state  <= WRITE;
          end else begin
            gnt <= '0;
          end
        end
        WRITE: begin
          en_out <= 1'b0;
          ack    <= gnt;
          state  <= ACK;
        end
        ACK: begin
          ack   <= '0;
          gnt   <= '0;
          owner <= win_q;
          ptr   <= ptr_next;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          en_out <= 1'b0;
          ack    <= '0;
          gnt    <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_registro_rr.sv
// Directed bench for arbitro_registro_rr with a model of the shared register.
module tb_arbitro_registro_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] d_in;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        en_out;
  logic [3:0]  d_out;
  logic [1:0]  owner;
  logic        busy;
  logic [3:0]  q;

  int total = 0;
  int bad   = 0;

  arbitro_registro_rr #(.N_REQ(4), .WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .d_in   (d_in),
    .gnt    (gnt),
    .ack    (ack),
    .en_out (en_out),
    .d_out  (d_out),
    .owner  (owner),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // shared enabled D register sitting behind the arbiter
  always_ff @(posedge clk) if (en_out) q <= d_out;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("en_ack_excl", {7'd0, en_out & (|ack)}, 8'd0);
      chk("ack_onehot", {7'd0, $countones(ack) > 1}, 8'd0);
      chk("gnt_onehot", {7'd0, $countones(gnt) > 1}, 8'd0);
    end
  end

  // Called at a negedge in IDLE with req already set; spans grant, write, ack.
  task automatic run_txn(input int w, input logic [3:0] data);
    logic [3:0] oh;
    oh = 4'(1 << w);
    @(negedge clk);
    chk("wr_gnt", {4'd0, gnt}, {4'd0, oh});
    chk("wr_en", {7'd0, en_out}, 8'd1);
    chk("wr_dout", {4'd0, d_out}, {4'd0, data});
    chk("wr_busy", {7'd0, busy}, 8'd1);
    chk("wr_ack", {4'd0, ack}, 8'd0);
    @(negedge clk);
    chk("ack_en", {7'd0, en_out}, 8'd0);
    chk("ack_bit", {4'd0, ack}, {4'd0, oh});
    chk("ack_q", {4'd0, q}, {4'd0, data});
    @(negedge clk);
    chk("idle_busy", {7'd0, busy}, 8'd0);
    chk("idle_gnt", {4'd0, gnt}, 8'd0);
    chk("idle_ack", {4'd0, ack}, 8'd0);
    chk("idle_owner", {6'd0, owner}, 8'(w));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    d_in  = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", {4'd0, gnt}, 8'd0);
    chk("rst_ack", {4'd0, ack}, 8'd0);
    chk("rst_en", {7'd0, en_out}, 8'd0);
    chk("rst_dout", {4'd0, d_out}, 8'd0);
    chk("rst_owner", {6'd0, owner}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    rst_n = 1'b1;

    // fairness with all four requesting
    run_txn(0, 4'b0001);
    run_txn(1, 4'b0010);
    run_txn(2, 4'b0100);
    run_txn(3, 4'b1000);
    run_txn(0, 4'b0001);

    // single write from requester 2
    req  = 4'b0100;
    d_in = {4'b0000, 4'b1010, 4'b0000, 4'b0000};
    run_txn(2, 4'b1010);

    // ptr=3, only requester 0 asks: wraps to 0
    req  = 4'b0001;
    d_in = {4'b0000, 4'b0000, 4'b0000, 4'b1111};
    run_txn(0, 4'b1111);

    // hold: nothing requested, data inputs change
    req  = 4'b0000;
    d_in = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_en", {7'd0, en_out}, 8'd0);
      chk("hold_dout", {4'd0, d_out}, 8'hf);
      chk("hold_q", {4'd0, q}, 8'hf);
      chk("hold_busy", {7'd0, busy}, 8'd0);
    end

    // requester 1 drops req during WRITE
    req  = 4'b0010;
    d_in = {4'b0000, 4'b0000, 4'b0110, 4'b0000};
    @(negedge clk);
    chk("drop_gnt", {4'd0, gnt}, 8'b0010);
    chk("drop_en", {7'd0, en_out}, 8'd1);
    req = 4'b0000;
    @(negedge clk);
    chk("drop_ack", {4'd0, ack}, 8'b0010);
    chk("drop_q", {4'd0, q}, 8'b0110);
    @(negedge clk);
    chk("drop_owner", {6'd0, owner}, 8'd1);
    chk("drop_busy", {7'd0, busy}, 8'd0);

    // reset during WRITE (ptr is 2 here)
    req  = 4'b0001;
    d_in = {4'b0000, 4'b0000, 4'b0000, 4'b0011};
    @(negedge clk);
    chk("mid_en", {7'd0, en_out}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", {7'd0, en_out}, 8'd0);
    chk("mid_rst_gnt", {4'd0, gnt}, 8'd0);
    chk("mid_rst_ack", {4'd0, ack}, 8'd0);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    chk("mid_rst_dout", {4'd0, d_out}, 8'd0);
    @(negedge clk);
    chk("mid_rst_noack", {4'd0, ack}, 8'd0);
    req   = 4'b1001;
    d_in  = {4'b1100, 4'b0000, 4'b0000, 4'b0101};
    rst_n = 1'b1;
    run_txn(0, 4'b0101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
